mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the CPU's instruction fetch (IF) and data access (MEM) stages.
- Sequences the two accesses in a fixed order and latches the returned read data.
- Drives IM_STALL and DM_STALL so the pipeline stays frozen until every access pending in the current cycle has completed.
- Sits between the CPU core and the shared memory wrapper at the top level.

Parameters:
- TIMEOUT_CYCLES, 255: busy cycles without mem_ack before the access is force-completed; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: value loaded into the read buffer on a timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Instr_read  in  1  IF request.
- PC_out  in  32  IF byte address.
- Instr_out  out  32  latched instruction.
- IM_STALL  out  1  IF stall.
- MEM_MemRead  in  1  DM read request.
- MEM_MemWrite  in  4  DM byte write enables, active-low; 4'hF means no write.
- MEM_ALU_out  in  32  DM byte address.
- data_in  in  32  DM write data, already lane-aligned.
- data_out  out  32  latched load data.
- DM_STALL  out  1  DM stall.
- mem_req  out  1  memory request, held high until ack or timeout.
- mem_web  out  4  active-low byte write enables to memory.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid in the mem_ack cycle.
- mem_ack  in  1  single-cycle completion pulse.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Definitions: im_pend = Instr_read; dm_pend = MEM_MemRead | (MEM_MemWrite != 4'hF). The CPU holds all request inputs stable while either stall is high.
- FSM states: IDLE, DM_BUSY, IF_BUSY, RELEASE.
- IDLE:
  - dm_pend → DM_BUSY.
  - else im_pend → IF_BUSY.
  - else stay in IDLE.
  - Data access has priority because it is older in program order.
- DM_BUSY:
  - mem_req=1, mem_addr=MEM_ALU_out, mem_web=MEM_MemWrite, mem_wdata=data_in.
  - On ack or timeout: → IF_BUSY if im_pend, else → RELEASE.
- IF_BUSY:
  - mem_req=1, mem_addr=PC_out, mem_web=4'hF, mem_wdata=0.
  - On ack or timeout: → RELEASE.
- RELEASE: → IDLE unconditionally. This state lasts exactly one cycle.
- Outside DM_BUSY and IF_BUSY: mem_req=0, mem_web=4'hF, mem_addr=0, mem_wdata=0.
- Stall outputs are combinational: IM_STALL = im_pend & (state != RELEASE); DM_STALL = dm_pend & (state != RELEASE).
  - Stalls assert in the same cycle a request appears in IDLE.
  - Both stalls drop together only in RELEASE, which gives one pipeline advance per transaction set.
  - Minimum cost: a lone access takes latency+2 cycles of stall-inclusive time (IDLE cycle, busy cycles, RELEASE).
- Read data latching:
  - mem_ack in IF_BUSY loads Instr_out from mem_rdata.
  - mem_ack in DM_BUSY with MEM_MemRead=1 loads data_out from mem_rdata.
  - A DM write leaves data_out unchanged.
  - Both buffers hold their value until the next load.
- Timeout:
  - An 8+ bit counter clears on entry to each BUSY state and increments each busy cycle without ack.
  - When the count reaches TIMEOUT_CYCLES (nonzero): mem_req drops, the active read buffer loads ERR_DATA (no load for a write), bus_err sets, and the FSM advances as if acked.
  - bus_err clears only on reset.
- Simultaneous events:
  - mem_ack in the same cycle the timeout fires: ack wins, bus_err is not set.
  - mem_ack outside a BUSY state is ignored.
- Reset (async, including mid-transaction):
  - state=IDLE, mem_req=0 immediately, Instr_out=0, data_out=0, bus_err=0, counter=0.
  - Any in-flight access is abandoned; the memory wrapper must tolerate mem_req falling without an ack.

Test Plan:
- Lone fetch, ack latency 3: Instr_read=1, PC_out=0x100, mem_rdata=0x00000013 → mem_req high 3 cycles with addr 0x100 and web=F; IM_STALL high 4 cycles, then low 1 cycle; Instr_out=0x13.
- Load plus fetch together: MEM_MemRead=1 at addr 0x2004, Instr_read=1 at 0x104, each acked after 2 cycles → DM access served first (addr 0x2004), then addr 0x104; data_out and Instr_out hold the respective rdata; both stalls drop in the same single cycle.
- Byte store: MEM_MemWrite=4'hD, data_in=0x0000AB00, addr 0x3001 → mem_web=4'hD, mem_wdata=0x0000AB00; data_out unchanged; RELEASE follows the ack.
- Timeout with TIMEOUT_CYCLES=4, load with no ack → mem_req drops after 4 busy cycles, data_out=0xDEADBEEF, bus_err=1 and stays 1 across later transactions. Repeat with ack arriving in the 4th busy cycle → bus_err stays 0.
- Async reset asserted mid-IF_BUSY between clock edges → mem_req=0 and Instr_out=0 without waiting for a clock edge. After reset deasserts with Instr_read=1, a fresh fetch starts from IDLE.
- No requests → stalls stay 0, mem_req stays 0; a spurious mem_ack changes no output.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one variable-latency memory port between instruction fetch
//            and data access, freezing the pipeline until every access is done.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Instr_read,
   input  logic [31:0] PC_out,
   output logic [31:0] Instr_out,
   output logic        IM_STALL,
   input  logic        MEM_MemRead,
   input  logic [3:0]  MEM_MemWrite,
   input  logic [31:0] MEM_ALU_out,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        DM_STALL,
   output logic        mem_req,
   output logic [3:0]  mem_web,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        bus_err
);

   localparam int CNT_W     = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
   localparam logic             TO_EN   = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DM_BUSY = 2'd1,
      ST_IF_BUSY = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      instr_q, instr_d;
   logic [31:0]      data_q, data_d;
   logic             err_q, err_d;

   logic             im_pend;
   logic             dm_pend;
   logic             to_fire;

   assign im_pend = Instr_read;
   assign dm_pend = MEM_MemRead | (MEM_MemWrite != 4'hF);
   // Timeout fires on the last allowed busy cycle; a coincident ack takes priority.
   assign to_fire = TO_EN && (cnt_q == TO_LAST) && !mem_ack;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (dm_pend)      state_d = ST_DM_BUSY;
            else if (im_pend) state_d = ST_IF_BUSY;
         end
         ST_DM_BUSY: begin
            if (mem_ack || to_fire) begin
               if (MEM_MemRead) data_d = mem_ack ? mem_rdata : ERR_DATA;
               if (!mem_ack)    err_d  = 1'b1;
               cnt_d   = '0;
               state_d = im_pend ? ST_IF_BUSY : ST_RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_IF_BUSY: begin
            if (mem_ack || to_fire) begin
               instr_d = mem_ack ? mem_rdata : ERR_DATA;
               if (!mem_ack) err_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         instr_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_web   = 4'hF;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ST_DM_BUSY: begin
            mem_req   = 1'b1;
            mem_web   = MEM_MemWrite;
            mem_addr  = MEM_ALU_out;
            mem_wdata = data_in;
         end
         ST_IF_BUSY: begin
            mem_req  = 1'b1;
            mem_addr = PC_out;
         end
         default: ;
      endcase
   end

   // Both stalls fall only in RELEASE, giving one pipeline advance per transaction set.
   assign IM_STALL  = im_pend & (state_q != ST_RELEASE);
   assign DM_STALL  = dm_pend & (state_q != ST_RELEASE);
   assign Instr_out = instr_q;
   assign data_out  = data_q;
   assign bus_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scoreboard bench with a latency-programmable memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        Instr_read;
   logic [31:0] PC_out;
   logic [31:0] Instr_out;
   logic        IM_STALL;
   logic        MEM_MemRead;
   logic [3:0]  MEM_MemWrite;
   logic [31:0] MEM_ALU_out;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        DM_STALL;
   logic        mem_req;
   logic [3:0]  mem_web;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack   = 1'b0;
   logic        bus_err;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  web;
      logic [31:0] wdata;
   } req_t;

   req_t        exp_q[$];
   logic [31:0] rd_q[$];
   int          ack_lat    = 0;
   logic        spurious   = 1'b0;
   int          busy_cnt   = 0;
   int          req_cycles = 0;
   int          vectors    = 0;
   int          miscompares = 0;

   mem_port_arbiter #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .rst(rst),
      .Instr_read(Instr_read), .PC_out(PC_out), .Instr_out(Instr_out), .IM_STALL(IM_STALL),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_ALU_out(MEM_ALU_out),
      .data_in(data_in), .data_out(data_out), .DM_STALL(DM_STALL),
      .mem_req(mem_req), .mem_web(mem_web), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory model: checks each new request against the scoreboard, acks after ack_lat cycles.
   always @(negedge clk) begin
      logic ack_prev;
      req_t e;
      ack_prev = mem_ack;
      mem_ack  = 1'b0;
      if (ack_prev) busy_cnt = 0;
      if (mem_req) begin
         req_cycles++;
         if (busy_cnt == 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_req", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("req_addr", mem_addr, e.addr);
               chk("req_web", {28'd0, mem_web}, {28'd0, e.web});
               chk("req_wdata", mem_wdata, e.wdata);
            end
         end
         busy_cnt++;
         if (busy_cnt == ack_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
         end
      end else begin
         busy_cnt  = 0;
         mem_ack   = spurious;
         mem_rdata = spurious ? 32'hBADBAD00 : 32'h0;
      end
   end

   task automatic push_req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      req_t e;
      e.addr = a; e.web = w; e.wdata = d;
      exp_q.push_back(e);
   endtask

   // Counts stalled cycles from the request cycle; ends at RELEASE (negedge + 1).
   task automatic run_txn(input string tag, input int exp_n);
      int n;
      n = 0;
      #1;
      while ((IM_STALL || DM_STALL) && n < 50) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk(tag, n, exp_n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      rst = 1'b1; Instr_read = 1'b0; PC_out = '0; MEM_MemRead = 1'b0;
      MEM_MemWrite = 4'hF; MEM_ALU_out = '0; data_in = '0;
      #3;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_web", {28'd0, mem_web}, 32'hF);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_instr", Instr_out, 32'd0);
      chk("rst_data", data_out, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
      chk("rst_stalls", {30'd0, IM_STALL, DM_STALL}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      // Lone fetch, latency 3
      r0 = req_cycles;
      Instr_read = 1'b1; PC_out = 32'h100; ack_lat = 3;
      push_req(32'h100, 4'hF, 32'h0); rd_q.push_back(32'h0000_0013);
      run_txn("fetch_stall_cycles", 4);
      chk("fetch_req_cycles", req_cycles - r0, 32'd3);
      chk("fetch_instr", Instr_out, 32'h13);
      Instr_read = 1'b0;
      @(negedge clk);

      // Load plus fetch: data side first
      MEM_MemRead = 1'b1; MEM_ALU_out = 32'h2004; Instr_read = 1'b1; PC_out = 32'h104;
      ack_lat = 2;
      push_req(32'h2004, 4'hF, 32'h0); push_req(32'h104, 4'hF, 32'h0);
      rd_q.push_back(32'hCAFE_0001); rd_q.push_back(32'h0040_0093);
      run_txn("dual_stall_cycles", 5);
      chk("dual_data", data_out, 32'hCAFE_0001);
      chk("dual_instr", Instr_out, 32'h0040_0093);
      MEM_MemRead = 1'b0; Instr_read = 1'b0;
      @(negedge clk);

      // Byte store
      MEM_MemWrite = 4'hD; data_in = 32'h0000_AB00; MEM_ALU_out = 32'h3001; ack_lat = 2;
      push_req(32'h3001, 4'hD, 32'h0000_AB00); rd_q.push_back(32'h5555_5555);
      run_txn("store_stall_cycles", 3);
      chk("store_data_kept", data_out, 32'hCAFE_0001);
      MEM_MemWrite = 4'hF; data_in = '0;
      @(negedge clk);

      // Load timeout
      r0 = req_cycles;
      MEM_MemRead = 1'b1; MEM_ALU_out = 32'h4000; ack_lat = 0;
      push_req(32'h4000, 4'hF, 32'h0);
      run_txn("to_stall_cycles", 5);
      chk("to_req_cycles", req_cycles - r0, 32'd4);
      chk("to_data", data_out, 32'hDEAD_BEEF);
      chk("to_bus_err", {31'd0, bus_err}, 32'd1);
      MEM_MemRead = 1'b0;
      @(negedge clk);

      // Sticky bus_err across a later fetch
      Instr_read = 1'b1; PC_out = 32'h108; ack_lat = 2;
      push_req(32'h108, 4'hF, 32'h0); rd_q.push_back(32'h0010_0113);
      run_txn("sticky_stall_cycles", 3);
      chk("sticky_instr", Instr_out, 32'h0010_0113);
      chk("sticky_bus_err", {31'd0, bus_err}, 32'd1);
      Instr_read = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("clr_bus_err", {31'd0, bus_err}, 32'd0);
      @(negedge clk);

      // Ack in the same cycle the timeout would fire
      r0 = req_cycles;
      MEM_MemRead = 1'b1; MEM_ALU_out = 32'h4004; ack_lat = 4;
      push_req(32'h4004, 4'hF, 32'h0); rd_q.push_back(32'h1234_5678);
      run_txn("race_stall_cycles", 5);
      chk("race_req_cycles", req_cycles - r0, 32'd4);
      chk("race_data", data_out, 32'h1234_5678);
      chk("race_bus_err", {31'd0, bus_err}, 32'd0);
      MEM_MemRead = 1'b0;
      @(negedge clk);

      Instr_read = 1'b1; PC_out = 32'h10C; ack_lat = 1;
      push_req(32'h10C, 4'hF, 32'h0); rd_q.push_back(32'h0000_0513);
      run_txn("lat1_stall_cycles", 2);
      chk("lat1_instr", Instr_out, 32'h0000_0513);
      Instr_read = 1'b0;
      @(negedge clk);

      // Async reset in the middle of a fetch
      Instr_read = 1'b1; PC_out = 32'h200; ack_lat = 0;
      push_req(32'h200, 4'hF, 32'h0);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("arst_instr", Instr_out, 32'd0);
      chk("arst_data", data_out, 32'd0);
      @(negedge clk);
      rst = 1'b0; ack_lat = 1;
      push_req(32'h200, 4'hF, 32'h0); rd_q.push_back(32'h0000_0297);
      run_txn("arst_refetch_cycles", 2);
      chk("arst_refetch_instr", Instr_out, 32'h0000_0297);
      Instr_read = 1'b0;
      @(negedge clk);

      // Idle with a spurious ack
      spurious = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("idle_stalls", {30'd0, IM_STALL, DM_STALL}, 32'd0);
         chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
         chk("idle_instr", Instr_out, 32'h0000_0297);
         chk("idle_data", data_out, 32'd0);
         chk("idle_bus_err", {31'd0, bus_err}, 32'd0);
      end
      spurious = 1'b0;
      @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
